// File: rtl/inst_fetch_stage.sv
// Fetch stage: owns the PC, drives the instruction ROM and fills the IF/ID latch.
// Handles stall, delayed-branch redirect, exception flush and halt.
module inst_fetch_stage #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [ADDR_WIDTH-1:0] FLUSH_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_i,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i,
  input  logic                  flush_i,
  input  logic                  halt_i,
  output logic                  rom_enable_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [INST_WIDTH-1:0] rom_inst_i,
  output logic [ADDR_WIDTH-1:0] id_pc_o,
  output logic [INST_WIDTH-1:0] id_inst_o,
  output logic                  id_valid_o,
  output logic                  id_addr_err_o
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] pc_reg;
  logic [ADDR_WIDTH-1:0] id_pc_reg;
  logic [INST_WIDTH-1:0] id_inst_reg;
  logic                  id_valid_reg;
  logic                  id_addr_err_reg;
  logic                  misaligned;

  assign misaligned    = |pc_reg[1:0];
  assign rom_enable_o  = (state_reg == RUN);
  assign rom_addr_o    = pc_reg;
  assign id_pc_o       = id_pc_reg;
  assign id_inst_o     = id_inst_reg;
  assign id_valid_o    = id_valid_reg;
  assign id_addr_err_o = id_addr_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= BOOT;
      pc_reg          <= RESET_PC;
      id_pc_reg       <= '0;
      id_inst_reg     <= '0;
      id_valid_reg    <= 1'b0;
      id_addr_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        BOOT: begin
          state_reg <= RUN;
          pc_reg    <= RESET_PC;
          if (!stall_i) begin
            id_valid_reg    <= 1'b0;
            id_inst_reg     <= '0;
            id_addr_err_reg <= 1'b0;
          end
        end
        RUN: begin
          if (flush_i) begin
            id_valid_reg    <= 1'b0;
            id_inst_reg     <= '0;
            id_addr_err_reg <= 1'b0;
            pc_reg          <= FLUSH_PC;
          end else begin
            if (halt_i) state_reg <= HALT;
            // A branch still lets the current word through: it is the delay slot.
            if (!stall_i) begin
              id_pc_reg       <= pc_reg;
              id_valid_reg    <= 1'b1;
              id_inst_reg     <= misaligned ? '0 : rom_inst_i;
              id_addr_err_reg <= misaligned;
              pc_reg          <= branch_i ? branch_addr_i : pc_reg + ADDR_WIDTH'(4);
            end
          end
        end
        HALT: begin
          if (flush_i) begin
            state_reg       <= RUN;
            pc_reg          <= FLUSH_PC;
            id_valid_reg    <= 1'b0;
            id_inst_reg     <= '0;
            id_addr_err_reg <= 1'b0;
          end else if (!stall_i) begin
            id_valid_reg    <= 1'b0;
            id_inst_reg     <= '0;
            id_addr_err_reg <= 1'b0;
          end
        end
        default: state_reg <= BOOT;
      endcase
    end
  end

endmodule
